// File: rtl/pixel_pkg.sv
// Shared pixel definitions: channel width default, pixel width derivation,
// and the {r,g,b} packing helper used by the word unpacker.
package pixel_pkg;

   localparam int unsigned CH_W_DEF = 4;
   // Widest channel the packing helper supports; callers cast down to PIX_W.
   localparam int unsigned CH_MAX   = 16;

   function automatic int unsigned pix_width(input int unsigned ch_w);
      return 3 * ch_w;
   endfunction

   localparam int unsigned PIX_W_DEF = pix_width(CH_W_DEF);

   // Red lands in the MSBs, blue in the LSBs.
   function automatic logic [3*CH_MAX-1:0] pack_pixel(
      input logic [CH_MAX-1:0] r,
      input logic [CH_MAX-1:0] g,
      input logic [CH_MAX-1:0] b,
      input int unsigned       ch_w
   );
      logic [3*CH_MAX-1:0] p;
      p = ({{(2*CH_MAX){1'b0}}, r} << (2 * ch_w))
        | ({{(2*CH_MAX){1'b0}}, g} << ch_w)
        |  {{(2*CH_MAX){1'b0}}, b};
      return p;
   endfunction

endpackage

// File: rtl/pixel_word_unpack.sv
// Combinational slicer: three channel words -> PPW packed {r,g,b} pixels,
// pixel 0 taken from the LSB slice of each word.
module pixel_word_unpack
   import pixel_pkg::*;
#(
   parameter int unsigned  CH_W   = CH_W_DEF,
   parameter int unsigned  WORD_W = 32,
   localparam int unsigned PPW    = WORD_W / CH_W,
   localparam int unsigned PIX_W  = pix_width(CH_W)
) (
   input  logic [WORD_W-1:0]          r_word,
   input  logic [WORD_W-1:0]          g_word,
   input  logic [WORD_W-1:0]          b_word,
   output logic [PPW-1:0][PIX_W-1:0]  pixels
);

   always_comb begin
      pixels = '0;
      for (int unsigned k = 0; k < PPW; k++) begin
         pixels[k] = PIX_W'(pack_pixel(CH_MAX'(r_word[k*CH_W +: CH_W]),
                                       CH_MAX'(g_word[k*CH_W +: CH_W]),
                                       CH_MAX'(b_word[k*CH_W +: CH_W]),
                                       CH_W));
      end
   end

endmodule

// File: rtl/pixel_stream_buffer.sv
// Pixel FIFO: accepts a full r/g/b word set (PPW pixels) per push and
// delivers one {r,g,b} pixel per pop, with sticky underrun and flush.
module pixel_stream_buffer
   import pixel_pkg::*;
#(
   parameter int unsigned  CH_W   = CH_W_DEF,
   parameter int unsigned  WORD_W = 32,
   parameter int unsigned  DEPTH  = 16,
   localparam int unsigned PPW    = WORD_W / CH_W,
   localparam int unsigned PIX_W  = pix_width(CH_W),
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [WORD_W-1:0] r_data,
   input  logic [WORD_W-1:0] g_data,
   input  logic [WORD_W-1:0] b_data,
   input  logic              r_rts,
   input  logic              g_rts,
   input  logic              b_rts,
   output logic              in_rtr,
   input  logic              flush,
   output logic [PIX_W-1:0]  current_pixel,
   output logic              out_rts,
   input  logic              out_rtr,
   output logic [LVL_W-1:0]  level,
   output logic              underrun
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PIX_W-1:0]           mem [DEPTH];
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [PPW-1:0][PIX_W-1:0]  lanes;
   logic                       push;
   logic                       pop;

   pixel_word_unpack #(
      .CH_W   (CH_W),
      .WORD_W (WORD_W)
   ) u_unpack (
      .r_word (r_data),
      .g_word (g_data),
      .b_word (b_data),
      .pixels (lanes)
   );

   always_comb begin
      in_rtr        = (LVL_W'(DEPTH) - level) >= LVL_W'(PPW);
      out_rts       = (level != '0);
      push          = r_rts & g_rts & b_rts & in_rtr;
      pop           = out_rts & out_rtr;
      current_pixel = out_rts ? mem[rd_ptr] : '0;
   end

   // Storage carries no reset; validity is tracked solely by level.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         for (int unsigned k = 0; k < PPW; k++) begin
            mem[wr_ptr + PTR_W'(k)] <= lanes[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         level    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         underrun <= 1'b0;
      end else if (flush) begin
         level    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         underrun <= 1'b0;
      end else begin
         level <= level + (push ? LVL_W'(PPW) : '0) - (pop ? LVL_W'(1) : '0);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(PPW);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (out_rtr && (level == '0)) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule
